// File: rtl/mem_access_stage.sv
// Memory-access stage of the pipelined OTTER core: turns M-stage load/store control
// into a req/ack data-memory transaction, stalls until it completes, and formats load data.
module mem_access_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ValidM,
    input  logic        RegWriteM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic        DmemAck,
    input  logic [31:0] DmemRdata,
    output logic [31:0] ReadDataM,
    output logic        RegWriteOutM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        MemFaultM,
    output logic        DmemReq,
    output logic        DmemWe,
    output logic [31:0] DmemAddr,
    output logic [31:0] DmemWdata,
    output logic [3:0]  DmemBe
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t      state, nextState;
    logic [7:0]  timeoutCnt;
    logic        fault;
    logic [31:0] captureData;
    logic [2:0]  funct3Q;
    logic [1:0]  byteOffQ;
    logic        access, misaligned, isHalf, isWord;

    function automatic logic [31:0] formatLoad(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
        logic [31:0] lane;
        lane = word >> {off, 3'b000};
        case (f3)
            3'b000:  formatLoad = {{24{lane[7]}}, lane[7:0]};
            3'b001:  formatLoad = {{16{lane[15]}}, lane[15:0]};
            3'b100:  formatLoad = {24'b0, lane[7:0]};
            3'b101:  formatLoad = {16'b0, lane[15:0]};
            default: formatLoad = word;
        endcase
    endfunction

    function automatic logic [31:0] storeLanes(input logic [2:0] f3, input logic [31:0] rs2);
        case (f3[1:0])
            2'b00:   storeLanes = {4{rs2[7:0]}};
            2'b01:   storeLanes = {2{rs2[15:0]}};
            default: storeLanes = rs2;
        endcase
    endfunction

    function automatic logic [3:0] storeEnables(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   storeEnables = 4'b0001 << off;
            2'b01:   storeEnables = 4'b0011 << off;
            default: storeEnables = 4'b1111;
        endcase
    endfunction

    assign access     = ValidM & (MemReadM | MemWriteM);
    assign isHalf     = (Funct3M[1:0] == 2'b01);
    assign isWord     = (Funct3M[1:0] == 2'b10);
    assign misaligned = access & ((isHalf & ALUResultM[0]) | (isWord & (ALUResultM[1:0] != 2'b00)));

    always_comb begin
        nextState    = state;
        StallM       = 1'b0;
        MisalignM    = 1'b0;
        MemFaultM    = 1'b0;
        ReadDataM    = 32'h0;
        RegWriteOutM = RegWriteM;
        DmemReq      = 1'b0;
        case (state)
            IDLE: begin
                if (misaligned) begin
                    MisalignM    = 1'b1;
                    RegWriteOutM = 1'b0;
                end else if (access) begin
                    StallM    = 1'b1;
                    nextState = WAIT;
                end
            end
            WAIT: begin
                DmemReq = 1'b1;
                StallM  = 1'b1;
                if (DmemAck || (timeoutCnt == LAST_CNT))
                    nextState = DONE;
            end
            DONE: begin
                ReadDataM    = captureData;
                MemFaultM    = fault;
                RegWriteOutM = RegWriteM & ~fault;
                nextState    = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= IDLE;
            DmemWe      <= 1'b0;
            DmemAddr    <= 32'h0;
            DmemWdata   <= 32'h0;
            DmemBe      <= 4'h0;
            captureData <= 32'h0;
            timeoutCnt  <= 8'h0;
            fault       <= 1'b0;
            funct3Q     <= 3'b0;
            byteOffQ    <= 2'b0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (access && !misaligned) begin
                        DmemAddr   <= {ALUResultM[31:2], 2'b00};
                        DmemWe     <= MemWriteM;
                        DmemBe     <= MemWriteM ? storeEnables(Funct3M, ALUResultM[1:0]) : 4'b1111;
                        DmemWdata  <= MemWriteM ? storeLanes(Funct3M, WriteDataM) : 32'h0;
                        funct3Q    <= Funct3M;
                        byteOffQ   <= ALUResultM[1:0];
                        timeoutCnt <= 8'h0;
                        fault      <= 1'b0;
                    end
                end
                WAIT: begin
                    // Ack on the threshold cycle still completes normally.
                    if (DmemAck) begin
                        captureData <= DmemWe ? 32'h0 : formatLoad(funct3Q, byteOffQ, DmemRdata);
                    end else if (timeoutCnt == LAST_CNT) begin
                        fault       <= 1'b1;
                        captureData <= 32'h0;
                    end else begin
                        timeoutCnt <= timeoutCnt + 8'd1;
                    end
                end
                DONE: fault <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
